// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its schedulers.
// Holds the state encoding, the default word width that matches the FIFO's
// write_data, and a constant-foldable clog2 helper for counter/index widths.
package fifo_arb_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_BURST = 1'b1;

  localparam int unsigned DEFAULT_DATA_W = 16;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority search.
// Ports:
//   req        in   N          request vector
//   last_owner in   IW         index of the previous winner
//   pick       out  N          one-hot winner (0 when no request)
//   pick_idx   out  IW         index of the winner
//   found      out  1          at least one request present
// The search starts at last_owner+1 and wraps, so last_owner has lowest priority.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          found
);

  // First set bit scanning upward cyclically from last_owner+1.
  always_comb begin
    logic [IW-1:0] idx;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(last_owner) + k) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing the FIFO write port among NUM_REQ
// producers. A granted producer owns the port for a burst of up to BURST_MAX
// accepted words, ended early by req_last on an accepted word or by dropping
// req. One idle arbitration cycle always separates bursts.
// Ports:
//   clk          in   1                 system clock, rising edge
//   reset        in   1                 asynchronous active-low reset
//   req          in   NUM_REQ           per-producer request
//   req_data     in   NUM_REQ*DATA_W    producer words, i at [i*DATA_W +: DATA_W]
//   req_last     in   NUM_REQ           final word of the producer's burst
//   ack          out  NUM_REQ           combinational one-hot: owner's word written
//   grant        out  NUM_REQ           registered one-hot owner, 0 when idle
//   fifo_full    in   1                 FIFO full flag
//   fifo_wr_en   out  1                 combinational FIFO write enable
//   fifo_wr_data out  DATA_W            owner's word, 0 when idle
//   stall        out  1                 owner requesting while FIFO full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      stall
);

  localparam int unsigned IW = clog2(NUM_REQ);
  localparam int unsigned CW = clog2(BURST_MAX + 1);

  localparam logic [CW-1:0] BEAT_LAST  = CW'(BURST_MAX - 1);
  localparam logic [IW-1:0] OWNER_INIT = IW'(NUM_REQ - 1);

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       last_owner;
  logic [CW-1:0]       beat_cnt;

  logic [NUM_REQ-1:0]  pick;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;

  logic                owner_req;
  logic                owner_last;
  logic [DATA_W-1:0]   owner_data;
  logic                write_ok;
  logic                burst_done;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .found      (pick_found)
  );

  // Owner's view of the producer inputs; other producers are ignored.
  always_comb begin
    owner_req  = req[owner];
    owner_last = req_last[owner];
    owner_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A word is accepted only in BURST with the owner requesting and room in the FIFO.
  assign write_ok = (state == ST_BURST) && owner_req && !fifo_full;

  // Burst ends on last/limit of an accepted word, or on an abandon (owner drops req).
  assign burst_done = (state == ST_BURST) &&
                      (!owner_req || (write_ok && (owner_last || (beat_cnt == BEAT_LAST))));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pick_found) state_next = ST_BURST;
      ST_BURST: if (burst_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs: everything is quiet outside BURST.
  always_comb begin
    ack          = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    stall        = 1'b0;
    if (state == ST_BURST) begin
      fifo_wr_en   = write_ok;
      ack[owner]   = write_ok;
      fifo_wr_data = owner_data;
      stall        = owner_req && fifo_full;
    end
  end

  // Ownership, beat counting and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= '0;
      owner      <= '0;
      last_owner <= OWNER_INIT;
      beat_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (pick_found) begin
        grant    <= pick;
        owner    <= pick_idx;
        beat_cnt <= '0;
      end
    end else begin
      if (write_ok) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
      if (burst_done) begin
        last_owner <= owner;
        grant      <= '0;
        beat_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive the DUT, a
// transaction-level round-robin model predicts the write order and burst
// owners, and a negedge monitor checks every FIFO write against the queue.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int BM = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_last;
  logic [NR-1:0]      ack;
  logic [NR-1:0]      grant;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_wr_data;
  logic               stall;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .ack          (ack),
    .grant        (grant),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .stall        (stall)
  );

  typedef struct {
    int            src;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] pq_data [NR][$];
  bit            pq_last [NR][$];
  exp_t          sb[$];
  int            exp_bursts[$];
  int            got_bursts[$];

  int            errors = 0;
  int            checks = 0;
  int            writes = 0;
  logic [NR-1:0] ack_seen = '0;
  logic [NR-1:0] pause = '0;
  bit            full_force = 1'b0;
  int            full_pct = 0;
  bit            gap_chk = 1'b1;
  bit            mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Present each producer's head word; empty or paused producers do not request.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (pq_data[i].size() > 0) begin
        req[i]              = !pause[i];
        req_data[i*DW +: DW] = pq_data[i][0];
        req_last[i]         = pq_last[i][0];
      end else begin
        req[i]              = 1'b0;
        req_data[i*DW +: DW] = 16'hDEAD;
        req_last[i]         = 1'($urandom);
      end
    end
  endtask

  // Driver: consume acked words after the edge, then re-drive inputs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (ack_seen[i] && pq_data[i].size() > 0) begin
          void'(pq_data[i].pop_front());
          void'(pq_last[i].pop_front());
        end
      end
      ack_seen  = '0;
      fifo_full = full_force || ($urandom_range(99) < full_pct);
      drive();
    end
  end

  // Monitor: invariants, scoreboard pops, burst-owner trace.
  initial begin
    logic [NR-1:0] prev_grant;
    int            idle_run;
    exp_t          e;
    prev_grant = '0;
    idle_run   = 0;
    forever begin
      @(negedge clk);
      if (mon_on && reset) begin
        chk("ack_onehot0", 32'($onehot0(ack)), 32'(1));
        chk("wr_en_eq_or_ack", 32'(fifo_wr_en), 32'(|ack));
        if (fifo_full) chk("no_write_when_full", 32'(fifo_wr_en), 32'(0));
        if (grant == '0) chk("idle_data_zero", 32'(fifo_wr_data), 32'(0));
        if (fifo_wr_en) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected none at %0t", fifo_wr_data, $time);
          end else begin
            e = sb.pop_front();
            chk("write_data", 32'(fifo_wr_data), 32'(e.data));
            chk("write_ack", 32'(ack), 32'(1) << e.src);
          end
          ack_seen = ack;
          writes++;
        end
        if (grant != '0 && prev_grant == '0) begin
          if (gap_chk && got_bursts.size() > 0) chk("idle_gap", 32'(idle_run), 32'(1));
          got_bursts.push_back($clog2(grant));
        end else if (grant != '0 && grant != prev_grant) begin
          chk("grant_direct_switch", 32'(grant), 32'(prev_grant));
        end
        idle_run   = (grant == '0) ? idle_run + 1 : 0;
        prev_grant = grant;
      end else begin
        prev_grant = grant;
        idle_run   = 0;
      end
    end
  end

  // Transaction-level reference: round robin over non-empty producers, each
  // burst taking words until a last flag, BURST_MAX words, or the queue empties.
  task automatic model();
    int rem [NR];
    int pos [NR];
    int last;
    int p;
    int n;
    bit lf;
    last = NR - 1;
    for (int i = 0; i < NR; i++) begin
      rem[i] = pq_data[i].size();
      pos[i] = 0;
    end
    while (1) begin
      p = -1;
      for (int k = 1; k <= NR; k++) begin
        if (p < 0 && rem[(last + k) % NR] > 0) p = (last + k) % NR;
      end
      if (p < 0) break;
      exp_bursts.push_back(p);
      n = 0;
      do begin
        sb.push_back('{src: p, data: pq_data[p][pos[p]]});
        lf = pq_last[p][pos[p]];
        pos[p]++;
        rem[p]--;
        n++;
      end while (!lf && n < BM && rem[p] > 0);
      last = p;
    end
  endtask

  task automatic load(input int p, input int n, input logic [DW-1:0] base, input int last_at);
    for (int j = 0; j < n; j++) begin
      pq_data[p].push_back(base + DW'(j));
      pq_last[p].push_back(j == last_at);
    end
  endtask

  task automatic start_scn();
    reset      = 1'b0;
    full_force = 1'b0;
    full_pct   = 0;
    pause      = '0;
    gap_chk    = 1'b1;
    ack_seen   = '0;
    for (int i = 0; i < NR; i++) begin
      pq_data[i].delete();
      pq_last[i].delete();
    end
    sb.delete();
    exp_bursts.delete();
    got_bursts.delete();
    writes = 0;
    drive();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_writes(input int k);
    int c;
    c = 0;
    while (writes < k && c < 200) begin
      @(negedge clk);
      #2;
      c++;
    end
    checks++;
    if (writes < k) begin
      errors++;
      $display("FAIL wait_writes: got %0d writes expected %0d", writes, k);
    end
  endtask

  task automatic run_done(input int budget);
    int  c;
    bit  busy;
    c    = 0;
    busy = 1'b1;
    while (busy && c < budget) begin
      busy = (sb.size() != 0);
      for (int i = 0; i < NR; i++) if (pq_data[i].size() != 0) busy = 1'b1;
      if (busy) begin
        @(negedge clk);
        #2;
        c++;
      end
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (3) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic check_bursts();
    int n;
    chk("burst_count", 32'(got_bursts.size()), 32'(exp_bursts.size()));
    n = (got_bursts.size() < exp_bursts.size()) ? got_bursts.size() : exp_bursts.size();
    for (int i = 0; i < n; i++) chk("burst_owner", 32'(got_bursts[i]), 32'(exp_bursts[i]));
  endtask

  initial begin
    reset     = 1'b0;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;
    req_last  = '0;

    // 1: all four requesting through reset; round robin 0,1,2,3, 4 words each.
    start_scn();
    for (int i = 0; i < NR; i++) load(i, 4, DW'((i + 1) * 16'h1000), -1);
    model();
    drive();
    repeat (2) @(negedge clk);
    #2;
    chk("reset_req_held", 32'(req), 32'hF);
    chk("reset_grant", 32'(grant), 32'(0));
    chk("reset_ack", 32'(ack), 32'(0));
    chk("reset_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("reset_wr_data", 32'(fifo_wr_data), 32'(0));
    chk("reset_stall", 32'(stall), 32'(0));
    mon_on = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    #2;
    chk("first_grant", 32'(grant), 32'h1);
    run_done(500);
    check_bursts();
    chk("t1_writes", 32'(writes), 32'(16));

    // 2: single producer, 6 words, split by BURST_MAX.
    start_scn();
    load(2, 6, 16'hA000, -1);
    model();
    reset = 1'b1;
    run_done(500);
    check_bursts();
    chk("t2_writes", 32'(writes), 32'(6));

    // 3: req_last on second word ends the burst; producer 3 goes next.
    start_scn();
    pq_data[1].push_back(16'h1111); pq_last[1].push_back(1'b0);
    pq_data[1].push_back(16'h2222); pq_last[1].push_back(1'b1);
    load(3, 3, 16'h3000, -1);
    model();
    reset = 1'b1;
    run_done(500);
    check_bursts();
    chk("t3_writes", 32'(writes), 32'(5));

    // 4: FIFO full for three cycles after the first word.
    start_scn();
    load(0, 4, 16'h4000, -1);
    model();
    reset = 1'b1;
    wait_writes(1);
    full_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      chk("full_stall", 32'(stall), 32'(1));
      chk("full_no_wr", 32'(fifo_wr_en), 32'(0));
      chk("full_grant_kept", 32'(grant), 32'h1);
    end
    full_force = 1'b0;
    run_done(500);
    check_bursts();
    chk("t4_writes", 32'(writes), 32'(4));

    // 5: owner abandons after one word; next grant skips past it.
    start_scn();
    load(1, 3, 16'h5100, -1);
    load(3, 2, 16'h5300, -1);
    sb.push_back('{src: 1, data: 16'h5100});
    sb.push_back('{src: 3, data: 16'h5300});
    sb.push_back('{src: 3, data: 16'h5301});
    sb.push_back('{src: 1, data: 16'h5101});
    sb.push_back('{src: 1, data: 16'h5102});
    exp_bursts.push_back(1);
    exp_bursts.push_back(3);
    exp_bursts.push_back(1);
    reset = 1'b1;
    wait_writes(1);
    pause[1] = 1'b1;
    @(negedge clk);
    #2;
    chk("abandon_no_wr", 32'(fifo_wr_en), 32'(0));
    chk("abandon_grant_held", 32'(grant), 32'h2);
    pause[1] = 1'b0;
    @(negedge clk);
    #2;
    chk("abandon_idle", 32'(grant), 32'(0));
    @(negedge clk);
    #2;
    chk("abandon_skip", 32'(grant), 32'h8);
    run_done(500);
    check_bursts();

    // 6: reset mid-burst after two words; producer 0 resends and wins first.
    start_scn();
    load(0, 4, 16'h6000, -1);
    load(1, 2, 16'h6100, -1);
    model();
    exp_bursts.delete();
    exp_bursts.push_back(0);
    exp_bursts.push_back(0);
    exp_bursts.push_back(1);
    gap_chk = 1'b0;
    reset   = 1'b1;
    wait_writes(2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_grant", 32'(grant), 32'(0));
    chk("midreset_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("midreset_ack", 32'(ack), 32'(0));
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("post_reset_grant", 32'(grant), 32'h1);
    run_done(500);
    check_bursts();

    // Randomized: random queue depths, last flags, data and FIFO back-pressure.
    for (int it = 0; it < 8; it++) begin
      int total;
      start_scn();
      full_pct = 30;
      total    = 0;
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 9);
        if (i == NR - 1 && total == 0) n = 3;
        for (int j = 0; j < n; j++) begin
          pq_data[i].push_back(16'($urandom));
          pq_last[i].push_back($urandom_range(0, 3) == 0);
        end
        total += n;
      end
      model();
      reset = 1'b1;
      run_done(3000);
      check_bursts();
      chk("rand_writes", 32'(writes), 32'(total));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
